vn_lut_load_ctrl: RTL and testbench

//  Sequencer for the write side of the symmetric 2-input VN IB-LUT (two banks, MULTI_FRAME_NUM pages/offset).
//  - Streams a complete LUT set from an upstream source into the shadow half (write_addr_offset = ~read_addr_offset).
//  - Swaps active/shadow halves on decoder request, so IB-LUTs update per iteration without stalling reads.

---
 rtl/vn_lut_load_ctrl_if.sv | 20 ++
 rtl/vn_lut_load_ctrl.sv | 109 ++++++++++
 tb/tb_vn_lut_load_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vn_lut_load_ctrl_if.sv
// Upstream LUT entry stream: one {bank1,bank0} entry per page, valid/ready handshake.
interface vn_lut_load_ctrl_if #(
  parameter int unsigned LUT_PORT_SIZE = 3
);
  logic [2*LUT_PORT_SIZE-1:0] lut_data_in;
  logic                       lut_data_valid;
  logic                       lut_data_ready;

  modport master (
    output lut_data_in,
    output lut_data_valid,
    input  lut_data_ready
  );

  modport slave (
    input  lut_data_in,
    input  lut_data_valid,
    output lut_data_ready
  );
endinterface

// File: rtl/vn_lut_load_ctrl.sv
// Write-side sequencer for the two-half VN IB-LUT: loads a full page set into the shadow half
// and swaps active/shadow halves on decoder request.
module vn_lut_load_ctrl #(
  parameter int unsigned LUT_PORT_SIZE   = 3,
  parameter int unsigned ENTRY_ADDR      = 5,
  parameter int unsigned MULTI_FRAME_NUM = 2,
  localparam int unsigned PAGE_AW        = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
  input  logic                     write_clk,
  input  logic                     rst,
  vn_lut_load_ctrl_if.slave        lut_src,
  input  logic                     load_start,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
  output logic [PAGE_AW-1:0]       page_write_addr,
  output logic                     write_addr_offset,
  output logic                     we,
  output logic                     read_addr_offset,
  output logic                     busy,
  output logic                     load_done,
  output logic                     shadow_valid
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e             state_q;
  logic [PAGE_AW-1:0] page_cnt_q;
  logic               shadow_sel_q;
  logic               ready_q;

  logic swap_go;
  logic read_off_next;
  logic xfer;

  always_comb begin
    swap_go       = (state_q == StIdle) && shadow_valid && swap_req;
    read_off_next = read_addr_offset ^ swap_go;
    xfer          = lut_src.lut_data_valid && ready_q;
  end

  assign lut_src.lut_data_ready = ready_q;
  assign busy                   = (state_q != StIdle);

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q           <= StIdle;
      page_cnt_q        <= '0;
      shadow_sel_q      <= 1'b0;
      ready_q           <= 1'b0;
      swap_ack          <= 1'b0;
      lut_in_bank0      <= '0;
      lut_in_bank1      <= '0;
      page_write_addr   <= '0;
      write_addr_offset <= 1'b0;
      we                <= 1'b0;
      read_addr_offset  <= 1'b0;
      load_done         <= 1'b0;
      shadow_valid      <= 1'b0;
    end else begin
      we        <= 1'b0;
      load_done <= 1'b0;
      swap_ack  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (swap_go) begin
            read_addr_offset <= ~read_addr_offset;
            swap_ack         <= 1'b1;
            shadow_valid     <= 1'b0;
          end
          // A same-cycle swap retargets the load at the half that was just retired.
          if (load_start) begin
            shadow_sel_q <= ~read_off_next;
            shadow_valid <= 1'b0;
            page_cnt_q   <= '0;
            ready_q      <= 1'b1;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          if (xfer) begin
            we                <= 1'b1;
            page_write_addr   <= page_cnt_q;
            write_addr_offset <= shadow_sel_q;
            lut_in_bank0      <= lut_src.lut_data_in[LUT_PORT_SIZE-1:0];
            lut_in_bank1      <= lut_src.lut_data_in[2*LUT_PORT_SIZE-1:LUT_PORT_SIZE];
            if (page_cnt_q == '1) begin
              ready_q   <= 1'b0;
              load_done <= 1'b1;
              state_q   <= StDone;
            end else begin
              page_cnt_q <= page_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          shadow_valid <= 1'b1;
          state_q      <= StIdle;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vn_lut_load_ctrl.sv
// Scoreboard bench for vn_lut_load_ctrl: drivers queue expected writes/events, a monitor checks them.
module tb_vn_lut_load_ctrl;
  localparam int unsigned LPS = 3;
  localparam int unsigned PN  = 16;

  logic       write_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack;
  logic [2:0] lut_in_bank0;
  logic [2:0] lut_in_bank1;
  logic [3:0] page_write_addr;
  logic       write_addr_offset;
  logic       we;
  logic       read_addr_offset;
  logic       busy;
  logic       load_done;
  logic       shadow_valid;

  vn_lut_load_ctrl_if #(.LUT_PORT_SIZE(LPS)) src ();

  vn_lut_load_ctrl #(
    .LUT_PORT_SIZE  (LPS),
    .ENTRY_ADDR     (5),
    .MULTI_FRAME_NUM(2)
  ) dut (
    .write_clk        (write_clk),
    .rst              (rst),
    .lut_src          (src),
    .load_start       (load_start),
    .swap_req         (swap_req),
    .swap_ack         (swap_ack),
    .lut_in_bank0     (lut_in_bank0),
    .lut_in_bank1     (lut_in_bank1),
    .page_write_addr  (page_write_addr),
    .write_addr_offset(write_addr_offset),
    .we               (we),
    .read_addr_offset (read_addr_offset),
    .busy             (busy),
    .load_done        (load_done),
    .shadow_valid     (shadow_valid)
  );

  always #5 write_clk = ~write_clk;

  int unsigned cyc = 0;
  always @(posedge write_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned stamp;
    logic [3:0]  page;
    logic        off;
    logic [2:0]  b0;
    logic [2:0]  b1;
  } wr_t;
  typedef struct {
    int unsigned stamp;
    logic        ro;
  } ack_t;

  wr_t         wr_q[$];
  int unsigned done_q[$];
  ack_t        ack_q[$];

  // Reference state: active half and whether the shadow half holds a complete set.
  logic m_ro = 1'b0;
  logic m_sv = 1'b0;

  always @(negedge write_clk) begin : monitor
    wr_t  e;
    ack_t a;
    if (we === 1'b1) begin
      chk("we_off_ne_read_off", 32'(write_addr_offset != read_addr_offset), 1);
      chk("ack_during_we", 32'(swap_ack), 0);
      if (wr_q.size() == 0) begin
        chk("unexpected_we", 0, 1);
      end else begin
        e = wr_q.pop_front();
        chk("we_latency", cyc, e.stamp);
        chk("page_addr", 32'(page_write_addr), 32'(e.page));
        chk("write_off", 32'(write_addr_offset), 32'(e.off));
        chk("bank0", 32'(lut_in_bank0), 32'(e.b0));
        chk("bank1", 32'(lut_in_bank1), 32'(e.b1));
      end
    end
    if (load_done === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_load_done", 0, 1);
      else chk("load_done_cycle", cyc, done_q.pop_front());
    end
    if (swap_ack === 1'b1) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_swap_ack", 0, 1);
      end else begin
        a = ack_q.pop_front();
        chk("swap_ack_cycle", cyc, a.stamp);
        chk("read_off_at_ack", 32'(read_addr_offset), 32'(a.ro));
      end
    end
  end

  // Called at a negedge with the DUT idle. vmode: 0 = steady valid with pattern data,
  // 1 = valid toggling, 2 = random valid. abort_at > 0 stops after that many transfers.
  task automatic load_set(input bit do_swap, input int vmode, input bit swap_mid,
                          input int abort_at);
    int         k;
    int         guard;
    logic       sh;
    logic [5:0] d;
    bit         v;
    k     = 0;
    guard = 0;
    load_start = 1'b1;
    if (do_swap) swap_req = 1'b1;
    if (do_swap && m_sv) begin
      m_ro = ~m_ro;
      ack_q.push_back('{cyc + 1, m_ro});
    end
    m_sv = 1'b0;
    sh   = ~m_ro;
    @(negedge write_clk);
    load_start = 1'b0;
    if (do_swap) swap_req = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    while (k < PN && guard < 400) begin
      guard++;
      if (abort_at > 0 && k == abort_at) break;
      chk("ready_in_load", 32'(src.lut_data_ready), 1);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 1;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      d = (vmode == 0) ? {3'(k + 1), 3'(k)} : 6'($urandom);
      src.lut_data_valid = v;
      src.lut_data_in    = v ? d : 6'($urandom);
      load_start         = (vmode == 2 && guard == 5);
      if (swap_mid && k == PN / 2) swap_req = 1'b1;
      if (v) begin
        wr_q.push_back('{cyc + 1, 4'(k), sh, d[2:0], d[5:3]});
        if (k == PN - 1) done_q.push_back(cyc + 1);
      end
      @(negedge write_clk);
      if (v) k++;
    end
    src.lut_data_valid = 1'b0;
    load_start         = 1'b0;
    if (abort_at > 0) return;
    chk("transfers_done", 32'(k), PN);
    chk("ready_after_last", 32'(src.lut_data_ready), 0);
    chk("busy_in_done", 32'(busy), 1);
    @(negedge write_clk);
    chk("busy_back_idle", 32'(busy), 0);
    chk("shadow_valid_set", 32'(shadow_valid), 1);
    m_sv = 1'b1;
  endtask

  task automatic swap_now();
    swap_req = 1'b1;
    if (m_sv) begin
      m_ro = ~m_ro;
      ack_q.push_back('{cyc + 1, m_ro});
      m_sv = 1'b0;
    end
    @(negedge write_clk);
    swap_req = 1'b0;
    chk("read_off_after_swap", 32'(read_addr_offset), 32'(m_ro));
    chk("shadow_clear_after_swap", 32'(shadow_valid), 32'(m_sv));
  endtask

  task automatic swap_refused();
    swap_req = 1'b1;
    repeat (5) begin
      @(negedge write_clk);
      chk("no_ack_without_shadow", 32'(swap_ack), 0);
      chk("read_off_held", 32'(read_addr_offset), 32'(m_ro));
    end
    swap_req = 1'b0;
  endtask

  initial begin : stim
    src.lut_data_valid = 1'b0;
    src.lut_data_in    = '0;
    repeat (2) @(negedge write_clk);
    chk("rst_we", 32'(we), 0);
    chk("rst_swap_ack", 32'(swap_ack), 0);
    chk("rst_bank0", 32'(lut_in_bank0), 0);
    chk("rst_bank1", 32'(lut_in_bank1), 0);
    chk("rst_page", 32'(page_write_addr), 0);
    chk("rst_write_off", 32'(write_addr_offset), 0);
    chk("rst_read_off", 32'(read_addr_offset), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_shadow_valid", 32'(shadow_valid), 0);
    chk("rst_ready", 32'(src.lut_data_ready), 0);
    rst = 1'b0;
    @(negedge write_clk);

    load_set(1'b0, 0, 1'b0, 0);
    // Reload over a valid shadow with backpressure; swap_req raised mid-load is held off.
    load_set(1'b0, 1, 1'b1, 0);
    swap_now();
    swap_refused();
    load_set(1'b0, 2, 1'b0, 0);
    load_set(1'b1, 2, 1'b0, 0);
    chk("read_off_after_combo", 32'(read_addr_offset), 32'(m_ro));
    swap_now();
    repeat (3) load_set(1'($urandom_range(0, 1)), 2, 1'b0, 0);
    if (!m_ro) swap_now();
    if (!m_sv) load_set(1'b0, 2, 1'b0, 0);

    load_set(1'b0, 2, 1'b0, 8);
    rst = 1'b1;
    @(negedge write_clk);
    rst  = 1'b0;
    m_ro = 1'b0;
    m_sv = 1'b0;
    chk("abort_we", 32'(we), 0);
    chk("abort_shadow_valid", 32'(shadow_valid), 0);
    chk("abort_read_off", 32'(read_addr_offset), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge write_clk);
    chk("abort_we_later", 32'(we), 0);
    swap_refused();

    repeat (2) @(negedge write_clk);
    chk("pending_writes", 32'(wr_q.size()), 0);
    chk("pending_done", 32'(done_q.size()), 0);
    chk("pending_acks", 32'(ack_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
